// File: rtl/rv32i_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the core.
// master: the fetch unit side; slave: the memory/core environment side.
interface rv32i_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    output fetch_fault
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    input  fetch_fault
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: sequential prefetch into a small FIFO with
// credit-limited memory requests, redirect flush and stale-response dropping.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_fetch_unit_if.master bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  cnt_t        out_q, out_d;
  cnt_t        occ_q, occ_d;
  cnt_t        drop_q, drop_d;
  logic        fault_q, fault_d;
  logic        req_v_q, req_v_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q   [FIFO_DEPTH];

  logic        hs;
  logic        pop;
  logic        rsp_drop;
  logic        rsp_live;
  logic        push;
  logic        has_head;
  logic [CW:0] credit_used;

  assign has_head = (occ_q != '0);
  assign hs       = req_v_q & bus.mem_req_ready;
  assign pop      = has_head & bus.instr_ready;
  assign rsp_drop = bus.mem_rsp_valid & (drop_q != '0);
  assign rsp_live = bus.mem_rsp_valid & (drop_q == '0) & (out_q != '0);
  assign push     = rsp_live & ~bus.redirect_valid;

  // Next-state for pointers, counters and PCs; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    occ_d      = occ_q;
    drop_d     = drop_q;
    fault_d    = fault_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      out_d      = '0;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // every still-live request becomes a drop token; a response arriving now
      // has already retired its own request (live or dropped)
      drop_d     = drop_q + out_q + cnt_t'(hs) - cnt_t'(rsp_drop) - cnt_t'(rsp_live);
      fault_d    = fault_q | (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      if (hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      out_d  = out_q + cnt_t'(hs) - cnt_t'(rsp_live);
      drop_d = drop_q - cnt_t'(rsp_drop);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Request valid is registered from the next-state credit so it is low in reset.
  always_comb begin
    credit_used = {1'b0, out_d} + {1'b0, occ_d};
    req_v_d     = (credit_used < (CW+1)'(FIFO_DEPTH)) && (drop_d == '0) && !fault_d;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
      fault_q    <= 1'b0;
      req_v_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
      req_v_q    <= req_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Prefetch FIFO storage: instruction word plus its PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= bus.mem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.mem_req_valid = req_v_q;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.instr_valid   = has_head;
  assign bus.instr_data    = has_head ? data_q[rd_ptr_q] : '0;
  assign bus.instr_pc      = has_head ? pc_q[rd_ptr_q] : '0;
  assign bus.fetch_fault   = fault_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: queue-based reference model,
// in-order memory responder with random latency, randomized handshakes.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv32i_fetch_unit_if ifc();

  rv32i_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference model: live requests in flight, dead (to-drop) count, buffered PCs
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_started;
  int          m_dead;
  logic [31:0] m_live[$];
  logic [31:0] m_fifo[$];

  // memory environment
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          p_rdy = 100, p_irdy = 100, lat_lo = 1, lat_hi = 1;

  // observed traffic
  logic [31:0] hs_log[$];
  logic [31:0] dv_pc[$];
  logic [31:0] dv_data[$];

  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_ipc, s_idata;

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] log_at(int which, int i);
    if (which == 0) return (i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF;
    if (which == 1) return (i < dv_pc.size()) ? dv_pc[i] : 32'hDEAD_BEEF;
    return (i < dv_data.size()) ? dv_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic bit m_req_v();
    return m_started && (m_live.size() + m_fifo.size() < DEPTH) && (m_dead == 0) && !m_fault;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_valid",   32'(ifc.mem_req_valid), 32'(m_req_v()));
      check("req_addr",    ifc.mem_req_addr, m_pc);
      check("instr_valid", 32'(ifc.instr_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        check("instr_pc",   ifc.instr_pc, m_fifo[0]);
        check("instr_data", ifc.instr_data, memf(m_fifo[0]));
      end
      check("fetch_fault", 32'(ifc.fetch_fault), 32'(m_fault));
      if (ifc.mem_rsp_valid)
        check("rsp_owner", 32'(m_live.size() + m_dead > 0), 32'd1);
    end
  end

  task automatic model_reset();
    m_pc = RPC; m_fault = 1'b0; m_started = 1'b0; m_dead = 0;
    m_live.delete(); m_fifo.delete();
  endtask

  task automatic model_update();
    bit hs, pop;
    hs  = m_req_v() && ifc.mem_req_ready;
    pop = (m_fifo.size() > 0) && ifc.instr_ready;
    if (pop) void'(m_fifo.pop_front());
    if (ifc.mem_rsp_valid) begin
      if (m_dead > 0) m_dead--;
      else if (m_live.size() > 0) m_fifo.push_back(m_live.pop_front());
    end
    if (hs) begin
      m_live.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (ifc.redirect_valid) begin
      m_dead += m_live.size();
      m_live.delete();
      m_fifo.delete();
      m_pc = ifc.redirect_pc;
      if (ifc.redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
    end
    m_started = 1'b1;
  endtask

  task automatic drive();
    ifc.mem_req_ready  = ($urandom_range(99) < p_rdy);
    ifc.instr_ready    = ($urandom_range(99) < p_irdy);
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = $urandom;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      ifc.mem_rsp_valid = 1'b1;
      ifc.mem_rsp_data  = memf(mq_addr[0]);
    end else begin
      ifc.mem_rsp_valid = 1'b0;
      ifc.mem_rsp_data  = $urandom;
    end
  endtask

  task automatic step();
    int d;
    @(negedge clk);
    s_rv = ifc.mem_req_valid; s_ra = ifc.mem_req_addr;
    s_iv = ifc.instr_valid; s_ipc = ifc.instr_pc; s_idata = ifc.instr_data;
    @(posedge clk);
    model_update();
    if (ifc.mem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    cyc++;
    if (s_rv && ifc.mem_req_ready) begin
      hs_log.push_back(s_ra);
      d = cyc + $urandom_range(lat_hi, lat_lo) - 1;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq_addr.push_back(s_ra);
      mq_due.push_back(d);
    end
    if (s_iv && ifc.instr_ready) begin
      dv_pc.push_back(s_ipc);
      dv_data.push_back(s_idata);
    end
    #1 drive();
  endtask

  task automatic redirect(logic [31:0] a);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = a;
    step();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.mem_rsp_valid  = 1'b0;
    ifc.mem_rsp_data   = '0;
    ifc.mem_req_ready  = 1'b0;
    ifc.instr_ready    = 1'b0;
    mq_addr.delete(); mq_due.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_due = cyc;
    chk_en = 1'b1;
    drive();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_rst_req_valid"}, 32'(ifc.mem_req_valid), 32'd0);
    check({tag, "_rst_req_addr"},  ifc.mem_req_addr, RPC);
    check({tag, "_rst_instr_valid"}, 32'(ifc.instr_valid), 32'd0);
    check({tag, "_rst_instr_data"},  ifc.instr_data, 32'd0);
    check({tag, "_rst_instr_pc"},    ifc.instr_pc, 32'd0);
    check({tag, "_rst_fault"},       32'(ifc.fetch_fault), 32'd0);
  endtask

  initial begin
    int base, k;
    logic [31:0] ra;

    // reset values and sequential streaming, 1-cycle latency
    do_reset();
    check_reset_values("t0");
    repeat (20) step();
    check("t1_hs0", log_at(0, 0), 32'h0040_0000);
    check("t1_hs1", log_at(0, 1), 32'h0040_0004);
    check("t1_hs2", log_at(0, 2), 32'h0040_0008);
    check("t1_pc0", log_at(1, 0), 32'h0040_0000);
    check("t1_pc1", log_at(1, 1), 32'h0040_0004);
    check("t1_pc2", log_at(1, 2), 32'h0040_0008);
    check("t1_data0", log_at(2, 0), 32'hC0DE_0040);
    check("t1_data1", log_at(2, 1), 32'hC0DA_0040);

    // core back-pressure from reset: credit caps in-flight+buffered at 2
    do_reset();
    base = hs_log.size();
    p_irdy = 0;
    repeat (10) step();
    check("t2_hs_count", 32'(hs_log.size() - base), 32'd2);
    check("t2_req_valid", 32'(ifc.mem_req_valid), 32'd0);
    check("t2_instr_valid", 32'(ifc.instr_valid), 32'd1);
    check("t2_instr_pc", ifc.instr_pc, 32'h0040_0000);
    base = dv_pc.size();
    p_irdy = 100;
    repeat (20) step();
    for (int i = 0; i < 6; i++)
      check("t2_resume_pc", log_at(1, base + i), RPC + 32'(4 * i));

    // memory stall, then asynchronous reset in the middle of it
    p_rdy = 0;
    repeat (5) step();
    p_rdy = 100;
    repeat (4) step();
    p_rdy = 0; p_irdy = 0;
    repeat (3) step();
    #2 rst = 1'b0;
    chk_en = 1'b0;
    #1 check_reset_values("t3");
    p_rdy = 100; p_irdy = 100;

    // redirect with two requests outstanding, 3-cycle latency
    do_reset();
    lat_lo = 3; lat_hi = 3;
    base = hs_log.size();
    k = 0;
    while (hs_log.size() - base < 2 && k < 20) begin
      step();
      k++;
    end
    check("t4_two_outstanding", 32'(hs_log.size() - base), 32'd2);
    base = dv_pc.size();
    redirect(32'h0000_1000);
    repeat (20) step();
    check("t4_first_pc", log_at(1, base), 32'h0000_1000);
    check("t4_second_pc", log_at(1, base + 1), 32'h0000_1004);

    // address wrap at the top of the 32-bit space
    lat_lo = 1; lat_hi = 2;
    redirect(32'hFFFF_FFF8);
    base = hs_log.size();
    repeat (15) step();
    check("t5_wrap0", log_at(0, base), 32'hFFFF_FFF8);
    check("t5_wrap1", log_at(0, base + 1), 32'hFFFF_FFFC);
    check("t5_wrap2", log_at(0, base + 2), 32'h0000_0000);

    // randomized traffic with random aligned redirects
    for (int blk = 0; blk < 12; blk++) begin
      p_rdy  = $urandom_range(100, 30);
      p_irdy = $urandom_range(100, 30);
      lat_lo = 1;
      lat_hi = $urandom_range(4, 1);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(99) < 4) begin
          ra = $urandom;
          if ($urandom_range(1) == 0) ra = ra & 32'h0000_FFFC;
          else ra = ra & 32'hFFFF_FFFC;
          redirect(ra);
        end else begin
          step();
        end
      end
    end

    // misaligned redirect: sticky fault, no further requests until reset
    p_rdy = 100; p_irdy = 100; lat_lo = 1; lat_hi = 3;
    repeat (5) step();
    redirect(32'h0000_1002);
    check("t7_fault_next", 32'(ifc.fetch_fault), 32'd1);
    base = hs_log.size();
    p_rdy = 60;
    repeat (20) step();
    check("t7_no_requests", 32'(hs_log.size() - base), 32'd0);
    check("t7_req_valid", 32'(ifc.mem_req_valid), 32'd0);
    check("t7_fault_sticky", 32'(ifc.fetch_fault), 32'd1);
    p_rdy = 0;
    repeat (2) step();
    #2 rst = 1'b0;
    chk_en = 1'b0;
    #1 check_reset_values("t7");

    // recovery after reset
    p_rdy = 100;
    do_reset();
    base = dv_pc.size();
    repeat (10) step();
    check("t8_restart_pc", log_at(1, base), RPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the RV32I core.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Captures in-order responses into a small prefetch FIFO and presents each instruction word with its PC to the core over a valid/ready channel.
- Handles control-flow redirects from the core by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2). Also the bound on outstanding plus buffered requests.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  core requests fetch restart this cycle.
- redirect_pc  input  32  new fetch address.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word address being fetched.
- mem_rsp_valid  input  1  response word valid; always accepted, in request order.
- mem_rsp_data  input  32  instruction word.
- instr_valid  output  1  instruction available to core.
- instr_ready  input  1  core consumes instruction.
- instr_data  output  32  instruction word to core.
- instr_pc  output  32  PC of instr_data.
- fetch_fault  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0.
  - Reset mid-transaction discards everything; late responses after reset deassertion are the memory's responsibility and are not tracked.
- Request issue:
  - mem_req_valid=1 when (outstanding + occupancy) < FIFO_DEPTH, drop_cnt==0, and fetch_fault==0.
  - mem_req_addr=fetch_pc, combinational from register.
  - A handshake is mem_req_valid & mem_req_ready. On handshake: fetch_pc += 4 (mod 2^32, wraps FFFF_FFFC→0000_0000) and outstanding++.
  - mem_req_valid is not withdrawn while it is high and ready is low, except on redirect.
- Response:
  - When mem_rsp_valid is high and drop_cnt>0: drop_cnt--; word discarded.
  - Otherwise the word is pushed to the FIFO with pc = rsp_pc; rsp_pc then += 4 and outstanding--.
  - rsp_pc tracks the PC of the oldest live outstanding request; it is loaded with fetch_pc at reset and redirect.
  - Response with outstanding==0 and drop_cnt==0 is a protocol error; ignore it and assert nothing (covered by assertion in bench).
- Delivery:
  - instr_valid = FIFO non-empty.
  - instr_data/instr_pc = head entry.
  - Pop on instr_valid & instr_ready.
  - Zero-latency bypass not required: minimum latency from response to instr_valid is 1 cycle (registered FIFO).
  - Simultaneous push and pop is allowed, including when full (pop frees the slot the same cycle). Credit rule guarantees no overflow.
- Redirect (redirect_valid=1), highest priority:
  - Next cycle: fetch_pc = rsp_pc = redirect_pc; FIFO flushed.
  - drop_cnt += outstanding, including a request handshaking this same cycle and excluding any response dropped/consumed this cycle; outstanding = 0.
  - A pop in the same cycle as redirect completes: the core consumed the old head.
  - A response arriving in the redirect cycle is discarded.
  - Requests resume the cycle after drop_cnt reaches 0. Back-to-back redirects accumulate drop_cnt.
- Misaligned redirect: redirect_pc[1:0]!=0 sets fetch_fault (sticky until reset) and blocks all further requests. FIFO flush still occurs.
- Counter widths: outstanding, occupancy, and drop_cnt are each clog2(FIFO_DEPTH)+1 bits. drop_cnt must never exceed FIFO_DEPTH.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response latency, instr_ready=1 → addresses 0x0040_0000, …04, …08 issued; instr_pc sequence matches; data equals memory model words.
- instr_ready=0 for 10 cycles → exactly 2 requests outstanding/buffered, mem_req_valid=0, instr_valid held on PC 0x0040_0000; then ready=1 → stream resumes without loss or duplicate.
- mem_req_ready stall 5 cycles → mem_req_valid and mem_req_addr stable throughout.
- Redirect to 0x0000_1000 with 2 requests outstanding (latency 3) → the two stale responses dropped; first instr_pc=0x0000_1000; no stale PC ever seen by core.
- fetch_pc at 0xFFFF_FFFC → next request address 0x0000_0000.
- Redirect to 0x0000_1002 → fetch_fault=1 next cycle, mem_req_valid stays 0 until rst asserted; rst low mid-stall → all outputs return to reset values asynchronously.
